// File: rtl/lsu_mem_initiator.sv
// Single-outstanding load/store initiator that drives the byte-addressable data memory port.
// Build option LSU_MISALIGN_TRAP_EN: misaligned requests report an error instead of being split into byte cycles.
module lsu_mem_initiator #(
  parameter int                AWIDTH    = 32,
  parameter int                DWIDTH    = 32,
  parameter logic [AWIDTH-1:0] BASE_ADDR = 32'h0100_0000,
  parameter logic [AWIDTH-1:0] MEM_BYTES = 32'h0010_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [AWIDTH-1:0] req_addr_i,
  input  logic [DWIDTH-1:0] req_wdata_i,
  output logic              resp_valid_o,
  output logic [DWIDTH-1:0] resp_rdata_o,
  output logic              resp_err_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [DWIDTH-1:0] mem_data_o,
  output logic              mem_read_en_o,
  output logic              mem_write_en_o,
  output logic [2:0]        mem_funct3_o,
  input  logic [DWIDTH-1:0] mem_data_i,
  output logic              busy_o
);

  // Two guard bits keep the window check free of modulo wrap.
  localparam int XW = AWIDTH + 2;
  localparam logic [XW-1:0] ONE_X     = {{(XW-2){1'b0}}, 2'b01};
  localparam logic [XW-1:0] THREE_X   = {{(XW-2){1'b0}}, 2'b11};
  localparam logic [XW-1:0] MEM_END_X = {2'b00, BASE_ADDR} + {2'b00, MEM_BYTES} - ONE_X;
  localparam logic [2:0]    F3_SB     = 3'b000;
  localparam logic [2:0]    F3_LBU    = 3'b100;

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, SPLIT = 2'd2, RESP = 2'd3} state_t;

  function automatic logic [2:0] access_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   access_size = 3'd1;
      2'b01:   access_size = 3'd2;
      default: access_size = 3'd4;
    endcase
  endfunction

  function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
    case (f3)
      3'd0, 3'd1, 3'd2: funct3_legal = 1'b1;
      3'd4, 3'd5:       funct3_legal = ~we;
      default:          funct3_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] byte_lane(input logic [31:0] w, input logic [1:0] k);
    case (k)
      2'd0:    byte_lane = w[7:0];
      2'd1:    byte_lane = w[15:8];
      2'd2:    byte_lane = w[23:16];
      default: byte_lane = w[31:24];
    endcase
  endfunction

  // Split loads leave the assembled value in the upper bytes of the shift register.
  function automatic logic [31:0] split_extend(input logic [2:0] f3, input logic [31:0] sh);
    case (f3)
      3'd1:    split_extend = {{16{sh[31]}}, sh[31:16]};
      3'd5:    split_extend = {16'h0000, sh[31:16]};
      default: split_extend = sh;
    endcase
  endfunction

  state_t              state_r;
  logic                we_r;
  logic [2:0]          f3_r;
  logic [AWIDTH-1:0]   addr_r;
  logic [DWIDTH-1:0]   wdata_r;
  logic [2:0]          size_r;
  logic [1:0]          k_r;
  logic [31:0]         asm_r;
  logic                ready_r;
  logic                resp_valid_r;
  logic [DWIDTH-1:0]   resp_rdata_r;
  logic                resp_err_r;
  logic [AWIDTH-1:0]   mem_addr_r;
  logic [DWIDTH-1:0]   mem_data_r;
  logic                mem_re_r;
  logic                mem_we_r;
  logic [2:0]          mem_f3_r;

  logic [2:0]          size_s;
  logic                misaligned_s;
  logic [XW-1:0]       a_last_x_s;
  logic                req_err_s;
  logic [1:0]          k_nxt_s;
  logic [31:0]         shift_s;

  // Classify the request currently presented on the request port.
  always_comb begin
    size_s       = access_size(req_funct3_i);
    misaligned_s = ((size_s == 3'd2) && req_addr_i[0]) ||
                   ((size_s == 3'd4) && (req_addr_i[1:0] != 2'b00));
    if (misaligned_s) begin
      a_last_x_s = {2'b00, req_addr_i} + {{(XW-3){1'b0}}, size_s} - ONE_X;
    end else begin
      a_last_x_s = {2'b00, req_addr_i};
    end
    req_err_s = ~funct3_legal(req_we_i, req_funct3_i) ||
                (req_addr_i < BASE_ADDR) ||
                ((a_last_x_s + THREE_X) > MEM_END_X);
`ifdef LSU_MISALIGN_TRAP_EN
    req_err_s = req_err_s || misaligned_s;
`else
    req_err_s = req_err_s;
`endif
  end

  // Byte-cycle helpers for the split path.
  always_comb begin
    k_nxt_s = k_r + 2'd1;
    shift_s = {mem_data_i[7:0], asm_r[31:8]};
  end

  // Request sequencing and registered port outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      we_r         <= 1'b0;
      f3_r         <= 3'd0;
      addr_r       <= {AWIDTH{1'b0}};
      wdata_r      <= {DWIDTH{1'b0}};
      size_r       <= 3'd0;
      k_r          <= 2'd0;
      asm_r        <= 32'h0000_0000;
      ready_r      <= 1'b0;
      resp_valid_r <= 1'b0;
      resp_rdata_r <= {DWIDTH{1'b0}};
      resp_err_r   <= 1'b0;
      mem_addr_r   <= {AWIDTH{1'b0}};
      mem_data_r   <= {DWIDTH{1'b0}};
      mem_re_r     <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_f3_r     <= 3'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid_i && ready_r) begin
            we_r    <= req_we_i;
            f3_r    <= req_funct3_i;
            addr_r  <= req_addr_i;
            wdata_r <= req_wdata_i;
            size_r  <= size_s;
            k_r     <= 2'd0;
            asm_r   <= 32'h0000_0000;
            ready_r <= 1'b0;
            if (req_err_s) begin
              resp_valid_r <= 1'b1;
              resp_err_r   <= 1'b1;
              resp_rdata_r <= {DWIDTH{1'b0}};
              state_r      <= RESP;
            end else if (misaligned_s) begin
              mem_addr_r <= req_addr_i;
              mem_f3_r   <= req_we_i ? F3_SB : F3_LBU;
              mem_re_r   <= ~req_we_i;
              mem_we_r   <= req_we_i;
              mem_data_r <= req_we_i ? {24'h00_0000, req_wdata_i[7:0]} : {DWIDTH{1'b0}};
              state_r    <= SPLIT;
            end else begin
              mem_addr_r <= req_addr_i;
              mem_f3_r   <= req_funct3_i;
              mem_re_r   <= ~req_we_i;
              mem_we_r   <= req_we_i;
              mem_data_r <= req_we_i ? req_wdata_i : {DWIDTH{1'b0}};
              state_r    <= ACCESS;
            end
          end else begin
            ready_r    <= 1'b1;
            mem_addr_r <= BASE_ADDR;
            mem_data_r <= {DWIDTH{1'b0}};
            mem_re_r   <= 1'b0;
            mem_we_r   <= 1'b0;
            mem_f3_r   <= 3'd0;
          end
        end
        ACCESS: begin
          mem_addr_r   <= BASE_ADDR;
          mem_data_r   <= {DWIDTH{1'b0}};
          mem_re_r     <= 1'b0;
          mem_we_r     <= 1'b0;
          mem_f3_r     <= 3'd0;
          resp_valid_r <= 1'b1;
          resp_err_r   <= 1'b0;
          resp_rdata_r <= we_r ? {DWIDTH{1'b0}} : mem_data_i;
          state_r      <= RESP;
        end
        SPLIT: begin
          if (!we_r) begin
            asm_r <= shift_s;
          end
          if ({1'b0, k_r} == (size_r - 3'd1)) begin
            mem_addr_r   <= BASE_ADDR;
            mem_data_r   <= {DWIDTH{1'b0}};
            mem_re_r     <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_f3_r     <= 3'd0;
            resp_valid_r <= 1'b1;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= we_r ? {DWIDTH{1'b0}} : split_extend(f3_r, shift_s);
            state_r      <= RESP;
          end else begin
            k_r        <= k_nxt_s;
            mem_addr_r <= addr_r + {{(AWIDTH-2){1'b0}}, k_nxt_s};
            mem_data_r <= we_r ? {24'h00_0000, byte_lane(wdata_r, k_nxt_s)} : {DWIDTH{1'b0}};
          end
        end
        RESP: begin
          resp_valid_r <= 1'b0;
          resp_err_r   <= 1'b0;
          resp_rdata_r <= {DWIDTH{1'b0}};
          ready_r      <= 1'b1;
          state_r      <= IDLE;
        end
        default: begin
          resp_valid_r <= 1'b0;
          resp_err_r   <= 1'b0;
          resp_rdata_r <= {DWIDTH{1'b0}};
          mem_re_r     <= 1'b0;
          mem_we_r     <= 1'b0;
          ready_r      <= 1'b0;
          state_r      <= IDLE;
        end
      endcase
    end
  end

  assign req_ready_o    = ready_r;
  assign resp_valid_o   = resp_valid_r;
  assign resp_rdata_o   = resp_rdata_r;
  assign resp_err_o     = resp_err_r;
  assign mem_addr_o     = mem_addr_r;
  assign mem_data_o     = mem_data_r;
  assign mem_read_en_o  = mem_re_r;
  assign mem_write_en_o = mem_we_r;
  assign mem_funct3_o   = mem_f3_r;
  assign busy_o         = (state_r != IDLE);

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Randomized scoreboard bench for lsu_mem_initiator with a byte-array memory and a reference model.
module tb_lsu_mem_initiator;

  localparam logic [31:0] BASE      = 32'h0100_0000;
  localparam logic [31:0] MEM_BYTES = 32'h0010_0000;
  localparam longint      MEM_END   = longint'(BASE) + longint'(MEM_BYTES) - 64'sd1;

  logic        clk, rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_re, mem_we, busy;
  logic [2:0]  mem_f3;

  lsu_mem_initiator #(.AWIDTH(32), .DWIDTH(32), .BASE_ADDR(BASE), .MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_funct3_i(req_funct3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
    .mem_addr_o(mem_addr), .mem_data_o(mem_wdata), .mem_read_en_o(mem_re),
    .mem_write_en_o(mem_we), .mem_funct3_o(mem_f3), .mem_data_i(mem_rdata), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          rd;
    int          wr;
    int          acc;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  mem[logic [31:0]];
  logic [7:0]  ref_mem[logic [31:0]];
  int          tests = 0, fails = 0, cyc = 0, last_resp_cyc = -100;
  int          rd_cnt = 0, wr_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  function automatic bit in_window(input logic [31:0] a);
    return (longint'(a) >= longint'(BASE)) && (longint'(a) <= MEM_END);
  endfunction

  // Reference: window/legality rules, little-endian byte gathering and extension.
  function automatic exp_t model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] wd);
    exp_t        e;
    int          size;
    bit          legal, mis, err;
    longint      alast;
    logic [31:0] v;
    legal = we ? (f3 <= 3'd2) : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    mis   = (size == 2 && a[0]) || (size == 4 && a[1:0] != 2'b00);
    alast = longint'(a) + (mis ? size - 1 : 0);
    err   = !legal || (a < BASE) || (alast + 3 > MEM_END);
`ifdef LSU_MISALIGN_TRAP_EN
    if (mis) err = 1'b1;
`endif
    e.err = err; e.rdata = 32'h0; e.acc = 0;
    if (err) begin
      e.lat = 1; e.rd = 0; e.wr = 0;
    end else begin
      e.lat = mis ? 1 + size : 2;
      e.rd  = we ? 0 : (mis ? size : 1);
      e.wr  = we ? (mis ? size : 1) : 0;
      if (we) begin
        for (int k = 0; k < size; k++) ref_mem[a + 32'(k)] = wd[8*k +: 8];
      end else begin
        v = 32'h0;
        for (int k = 0; k < size; k++) v[8*k +: 8] = ref_byte(a + 32'(k));
        if (f3 == 3'd0) v = {{24{v[7]}}, v[7:0]};
        if (f3 == 3'd1) v = {{16{v[15]}}, v[15:0]};
        e.rdata = v;
      end
    end
    return e;
  endfunction

  function automatic logic [31:0] mem_read(input logic [31:0] a, input logic [2:0] f3);
    logic [31:0] w;
    w = 32'h0;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = mem_byte(a + 32'(k));
    case (f3)
      3'd0:    return {{24{w[7]}}, w[7:0]};
      3'd1:    return {{16{w[15]}}, w[15:0]};
      3'd4:    return {24'h0, w[7:0]};
      3'd5:    return {16'h0, w[15:0]};
      default: return w;
    endcase
  endfunction

  // Memory: commits writes and presents read data mid-cycle, ahead of the sampling edge.
  always @(negedge clk) begin
    if (rst && mem_we) begin
      for (int k = 0; k < ((mem_f3[1:0] == 2'd0) ? 1 : (mem_f3[1:0] == 2'd1) ? 2 : 4); k++)
        if (in_window(mem_addr + 32'(k))) mem[mem_addr + 32'(k)] = mem_wdata[8*k +: 8];
    end
    mem_rdata = mem_read(mem_addr, mem_f3);
  end

  // Monitor: pops the scoreboard on every response pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (mem_re) rd_cnt++;
      if (mem_we) wr_cnt++;
      if (busy) chk("ready_while_busy", {31'h0, req_ready}, 32'h0);
      if (resp_valid) begin
        last_resp_cyc = cyc;
        if (q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_resp: rdata %h err %b with empty scoreboard", resp_rdata, resp_err);
        end else begin
          e = q.pop_front();
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_err", {31'h0, resp_err}, {31'h0, e.err});
          chk("resp_latency", cyc - e.acc, e.lat);
          chk("read_cycles", rd_cnt, e.rd);
          chk("write_cycles", wr_cnt, e.wr);
        end
        rd_cnt = 0; wr_cnt = 0;
      end else begin
        chk("idle_resp_zero", resp_rdata | {31'h0, resp_err}, 32'h0);
      end
    end
  end

  function automatic logic [31:0] any_out();
    return {31'h0, |{req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata,
                     mem_re, mem_we, mem_f3, busy}};
  endfunction

  // Call at a negedge; returns at the negedge after acceptance.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input bit hold, input bit push, input bit chk_b2b);
    exp_t e;
    int   n;
    req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      tests++; fails++;
      $display("FAIL accept_timeout: req_ready 0 after %0d cycles for addr %h", n, a);
      req_valid = 1'b0;
      return;
    end
    if (chk_b2b) chk("b2b_accept_cycle", cyc, last_resp_cyc + 1);
    if (push) begin
      e = model(we, f3, a, wd);
      e.acc = cyc;
      q.push_back(e);
    end
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      mem[a + 32'(k)]     = w[8*k +: 8];
      ref_mem[a + 32'(k)] = w[8*k +: 8];
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit          hold, prev_hold;
    int          sel, n;
    logic [31:0] a;
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0; mem_rdata = 32'h0;
    #1;
    chk("reset_outputs_zero", any_out(), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {31'h0, req_ready}, 32'h1);
    chk("idle_mem_addr", mem_addr, BASE);

    preload(32'h0100_0004, 32'h1122_3344);
    issue(1'b0, 3'd2, 32'h0100_0004, 32'h0, 1'b0, 1'b1, 1'b0);
    issue(1'b1, 3'd1, 32'h0100_0003, 32'h0000_BEEF, 1'b0, 1'b1, 1'b0);
    issue(1'b0, 3'd5, 32'h0100_0003, 32'h0, 1'b0, 1'b1, 1'b0);
    issue(1'b1, 3'd0, 32'h0100_0010, 32'h0000_0080, 1'b0, 1'b1, 1'b0);
    issue(1'b0, 3'd0, 32'h0100_0010, 32'h0, 1'b0, 1'b1, 1'b0);
    issue(1'b0, 3'd4, 32'h0100_0010, 32'h0, 1'b0, 1'b1, 1'b0);
    issue(1'b1, 3'd2, 32'h0100_0010, 32'h8000_0080, 1'b0, 1'b1, 1'b0);
    issue(1'b0, 3'd2, 32'h0100_0010, 32'h0, 1'b0, 1'b1, 1'b0);
    issue(1'b0, 3'd2, 32'h00FF_FFFC, 32'h0, 1'b0, 1'b1, 1'b0);
    issue(1'b0, 3'd2, 32'h010F_FFFD, 32'h0, 1'b0, 1'b1, 1'b0);
    issue(1'b0, 3'd3, 32'h0100_0000, 32'h0, 1'b0, 1'b1, 1'b0);
    issue(1'b1, 3'd4, 32'h0100_0000, 32'h5A5A_5A5A, 1'b0, 1'b1, 1'b0);
    issue(1'b0, 3'd2, 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b1, 1'b0);
    issue(1'b0, 3'd0, 32'h010F_FFFC, 32'h0, 1'b0, 1'b1, 1'b0);
    issue(1'b0, 3'd0, 32'h010F_FFFD, 32'h0, 1'b0, 1'b1, 1'b0);
    issue(1'b0, 3'd1, 32'h0100_0011, 32'h0, 1'b0, 1'b1, 1'b0);
    issue(1'b0, 3'd2, 32'h0100_0004, 32'h0, 1'b1, 1'b1, 1'b0);
    issue(1'b0, 3'd2, 32'h0100_0010, 32'h0, 1'b0, 1'b1, 1'b1);

`ifndef LSU_MISALIGN_TRAP_EN
    preload(32'h0100_0020, 32'h0000_0000);
    preload(32'h0100_0024, 32'h0000_0000);
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    issue(1'b1, 3'd2, 32'h0100_0021, 32'hA1B2_C3D4, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("abort_outputs_zero", any_out(), 32'h0);
    ref_mem[32'h0100_0021] = 8'hD4;
    rd_cnt = 0; wr_cnt = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_abort", {31'h0, req_ready}, 32'h1);
    issue(1'b0, 3'd2, 32'h0100_0020, 32'h0, 1'b0, 1'b1, 1'b0);
    issue(1'b0, 3'd2, 32'h0100_0024, 32'h0, 1'b0, 1'b1, 1'b0);
`endif

    prev_hold = 1'b0;
    for (int i = 0; i < 300; i++) begin
      sel = int'($urandom_range(15, 0));
      case (sel)
        12:      a = BASE - 32'($urandom_range(8, 1));
        13:      a = 32'(MEM_END) - 32'($urandom_range(7, 0));
        14:      a = 32'hFFFF_FFF8 + 32'($urandom_range(7, 0));
        15:      a = BASE + ($urandom % MEM_BYTES);
        default: a = BASE + 32'($urandom_range(63, 0));
      endcase
      hold = 1'($urandom_range(1, 0));
      issue(1'($urandom_range(1, 0)), 3'($urandom_range(7, 0)), a, $urandom, hold, 1'b1, prev_hold);
      prev_hold = hold;
    end
    req_valid = 1'b0;

    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain_timeout: %0d responses still outstanding", q.size());
    end
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
